// File: rtl/death_ctrl_if.sv
// Handshake bundle between the collision detector / game logic and death_ctrl.
// DEATH_STATS_EN adds the total_deaths session statistic.
interface death_ctrl_if;
  logic       col;
  logic       start;
  logic [2:0] lives;
  logic       freeze;
  logic       respawn;
  logic       invuln;
  logic       game_over;
`ifdef DEATH_STATS_EN
  logic [7:0] total_deaths;
`endif

  modport master (
    output col, start,
`ifdef DEATH_STATS_EN
    input  total_deaths,
`endif
    input  lives, freeze, respawn, invuln, game_over
  );

  modport slave (
    input  col, start,
`ifdef DEATH_STATS_EN
    output total_deaths,
`endif
    output lives, freeze, respawn, invuln, game_over
  );
endinterface

// File: rtl/death_ctrl.sv
// Pac-Man death sequencer: debounced collision -> lives decrement, freeze, respawn, grace.
// Optional DEATH_STATS_EN adds a saturating total_deaths counter.
module death_ctrl #(
  parameter int LIVES_INIT    = 3,
  parameter int CONFIRM       = 2,
  parameter int FREEZE_CYCLES = 25000000,
  parameter int GRACE_CYCLES  = 50000000,
  parameter int CNT_W         = 26
) (
  input  logic          clk,
  input  logic          rst_n,
  death_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PLAY    = 3'd1,
    DYING   = 3'd2,
    RESPAWN = 3'd3,
    GRACE   = 3'd4,
    OVER    = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] FREEZE_LAST = CNT_W'(FREEZE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GRACE_LAST  = CNT_W'(GRACE_CYCLES - 1);
  localparam logic [3:0]       CONF_LAST   = 4'(CONFIRM - 1);
  localparam logic [2:0]       LIVES_LOAD  = 3'(LIVES_INIT);

  state_t           state;
  logic [CNT_W-1:0] timer;
  logic [3:0]       conf_cnt;
  logic [2:0]       lives_r;
  logic             freeze_r;
  logic             respawn_r;
  logic             invuln_r;
  logic             game_over_r;
`ifdef DEATH_STATS_EN
  logic [7:0]       deaths_r;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      timer       <= '0;
      conf_cnt    <= '0;
      lives_r     <= '0;
      freeze_r    <= 1'b1;
      respawn_r   <= 1'b0;
      invuln_r    <= 1'b0;
      game_over_r <= 1'b0;
`ifdef DEATH_STATS_EN
      deaths_r    <= '0;
`endif
    end else begin
      respawn_r <= 1'b0;
      case (state)
        IDLE, OVER: begin
          // start has priority; col is ignored on the starting edge
          conf_cnt <= '0;
          if (bus.start) begin
            state       <= PLAY;
            lives_r     <= LIVES_LOAD;
            freeze_r    <= 1'b0;
            game_over_r <= 1'b0;
          end
        end
        PLAY: begin
          if (!bus.col) begin
            conf_cnt <= '0;
          end else if (conf_cnt == CONF_LAST && lives_r != 3'd0) begin
            conf_cnt <= '0;
            lives_r  <= lives_r - 3'd1;
            freeze_r <= 1'b1;
`ifdef DEATH_STATS_EN
            if (deaths_r != 8'hFF) deaths_r <= deaths_r + 8'd1;
`endif
            if (lives_r == 3'd1) begin
              state       <= OVER;
              game_over_r <= 1'b1;
            end else begin
              state <= DYING;
              timer <= '0;
            end
          end else begin
            conf_cnt <= conf_cnt + 4'd1;
          end
        end
        DYING: begin
          conf_cnt <= '0;
          timer    <= timer + 1'b1;
          if (timer == FREEZE_LAST) begin
            state     <= RESPAWN;
            respawn_r <= 1'b1;
            timer     <= '0;
          end
        end
        RESPAWN: begin
          conf_cnt <= '0;
          timer    <= '0;
          state    <= GRACE;
          freeze_r <= 1'b0;
          invuln_r <= 1'b1;
        end
        GRACE: begin
          conf_cnt <= '0;
          timer    <= timer + 1'b1;
          if (timer == GRACE_LAST) begin
            state    <= PLAY;
            invuln_r <= 1'b0;
            timer    <= '0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.lives     = lives_r;
  assign bus.freeze    = freeze_r;
  assign bus.respawn   = respawn_r;
  assign bus.invuln    = invuln_r;
  assign bus.game_over = game_over_r;
`ifdef DEATH_STATS_EN
  assign bus.total_deaths = deaths_r;
`endif

endmodule

// File: doc/death_ctrl.md
Name: death_ctrl

Overview:
- Sits directly downstream of the Pac-Man/monster collision detector. Consumes its `col` flag and turns it into the game's death sequence.
- Filters glitchy collisions and decrements lives.
- Freezes movement during the death animation, pulses a respawn request, then grants a short invulnerability window.
- Drives `game_over` when lives run out; `start` begins or restarts a game.

Parameters:
- LIVES_INIT, 3, lives loaded on game start (1..7).
- CONFIRM, 2, consecutive cycles `col` must be high to count as a hit (1..15).
- FREEZE_CYCLES, 25000000, cycles `freeze` stays high in DYING (1 s at 25 MHz).
- GRACE_CYCLES, 50000000, cycles of invulnerability after respawn.
- CNT_W, 26, width of the shared timer counter; must hold max(FREEZE_CYCLES, GRACE_CYCLES).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- col  in  1  collision flag from the collision detector, level, may glitch
- start  in  1  start/restart request, level-sampled
- lives  out  3  remaining lives
- freeze  out  1  high = Pac-Man and monster movement must hold position
- respawn  out  1  one-cycle pulse: reload sprite start positions
- invuln  out  1  high during grace period; drives sprite blink
- game_over  out  1  high while in OVER
- total_deaths  out  8  only when DEATH_STATS_EN is defined (see Optional Feature)

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-low.
  - All outputs are registered.
  - Reset values: state=IDLE, lives=0, freeze=1, respawn=0, invuln=0, game_over=0, timer=0, confirm count=0.
- States: IDLE, PLAY, DYING, RESPAWN, GRACE, OVER.
- IDLE:
  - freeze=1.
  - If `start`=1 at an edge, go to PLAY, lives<=LIVES_INIT, freeze<=0.
- PLAY:
  - freeze=0, invuln=0.
  - The confirm counter increments each cycle `col`=1 and clears when `col`=0.
  - When `col`=1 and counter==CONFIRM-1 (i.e. the CONFIRM-th consecutive high sample):
    - lives<=lives-1 and freeze<=1, on that same edge.
    - If lives was 1, go to OVER (lives becomes 0, game_over<=1).
    - Otherwise go to DYING with timer<=0.
  - CONFIRM=1 means a hit on the first high sample.
- DYING:
  - freeze=1; timer increments each cycle.
  - When timer==FREEZE_CYCLES-1, go to RESPAWN.
  - Freeze therefore lasts exactly FREEZE_CYCLES cycles.
- RESPAWN:
  - Single cycle: respawn=1, freeze=1, timer<=0.
  - Next state GRACE: respawn<=0, freeze<=0, invuln<=1.
- GRACE:
  - invuln=1; `col` is ignored and the confirm counter is held at 0.
  - Timer increments; when timer==GRACE_CYCLES-1, go to PLAY with invuln<=0.
- OVER:
  - game_over=1, freeze=1, lives=0.
  - `start`=1 goes to PLAY with lives<=LIVES_INIT and game_over<=0.
- Confirm counter: cleared on every state change, so a held `col` across GRACE→PLAY needs a full CONFIRM run.
- `start` is ignored in PLAY, DYING, RESPAWN and GRACE.
- Simultaneous events:
  - In OVER/IDLE, `start` wins; `col` is ignored that cycle.
  - In PLAY, `start` together with a confirmed hit resolves as a hit.
- rst_n=0 in any state, including mid-DYING or mid-GRACE, returns to the reset values on that edge. No respawn pulse is emitted.
- Width rules:
  - lives never underflows; decrement happens only in PLAY with lives≥1.
  - Timer compares are exact equality on CNT_W bits.

Optional Feature:
- DEATH_STATS_EN defined:
  - Adds output `total_deaths` [7:0].
  - Reset 0; increments on every confirmed hit; saturates at 255.
  - Not cleared by `start` (session statistic).
- Not defined: port and counter absent; all other behaviour identical.

Test Plan:
- Params LIVES_INIT=3, CONFIRM=2, FREEZE_CYCLES=4, GRACE_CYCLES=6 throughout.
- Start: rst_n low 2 cycles, then start=1 one cycle -> lives=3, freeze=0, game_over=0 next cycle.
- Glitch rejection: in PLAY, `col` high 1 cycle, low, high 1 cycle -> lives stays 3, freeze stays 0.
- Death sequence: `col` high 2 cycles -> lives=2 and freeze=1 after 2nd edge; freeze high exactly 4 cycles; then respawn=1 one cycle; then invuln=1 for 6 cycles with `col` held high and lives stays 2; back in PLAY with `col` still high, lives=1 after 2 further cycles.
- Game over: from lives=1, confirmed hit -> lives=0, game_over=1, freeze=1, no respawn pulse. Then start=1 and col=1 together -> lives=3, game_over=0, no hit counted.
- Reset mid-op: assert rst_n=0 at DYING timer=2 -> next cycle lives=0, freeze=1, respawn=0, invuln=0, state IDLE.
- Stats (DEATH_STATS_EN): 3 hits, then restart, then 1 hit -> total_deaths=4.
